minicpu_core: RTL and testbench
===============================

Name: minicpu_core

Overview:
- Parametrised successor to the 2-register minimal processor.
- Configurable data width, address width and register-file depth, plus an 8-opcode ISA: NOP, LOAD, STORE, ADD, SUB, JMP, JZ, HALT.
- Multicycle FETCH/DECODE/EXEC/MEM state machine, so there are no hazards and no bus contention.
- Sits between the clock/reset tree and a single synchronous RAM holding both program and data.

Parameters:
- DATA_W, 16, width of registers, memory words and instruction words.
- ADDR_W, 8, RAM address width; PC width.
- NREG, 4, number of general registers (power of 2, >=2); REG_AW = clog2(NREG).
- Elaboration check: DATA_W >= 3 + 2*REG_AW + ADDR_W.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ram_data_read  in  DATA_W  RAM read data, valid the cycle after ram_read_e.
- ram_addr_read  out  ADDR_W  RAM read address.
- ram_read_e  out  1  read enable.
- ram_data_write  out  DATA_W  RAM write data.
- ram_addr_write  out  ADDR_W  RAM write address.
- ram_write_e  out  1  write enable, one-cycle pulse.
- pc  out  ADDR_W  current program counter.
- zero_flag  out  1  result==0 from the last ADD/SUB.
- carry_flag  out  1  carry (ADD) or borrow (SUB) from the last ADD/SUB.
- halted  out  1  core is in the HALT state.

Behaviour:
- Reset (asynchronous, active-high):
  - state=FETCH, pc=0, all registers=0, flags=0, instruction register=0.
  - While rst is high: ram_read_e=1, ram_addr_read=0, ram_write_e=0, ram_data_write=0, ram_addr_write=0, halted=0.
- Reset mid-operation: state returns to FETCH immediately. A STORE pulse in flight is cut the same instant, because write outputs decode from state.
- Instruction fields (LSB first): op[2:0], rd[3+:REG_AW], rs[3+REG_AW+:REG_AW], addr[3+2*REG_AW+:ADDR_W]. Upper bits are ignored.
- Opcodes:
  - 000 NOP
  - 001 LOAD: rd<=M[addr]
  - 010 STORE: M[addr]<=R[rs]
  - 011 ADD: rd<=rd+rs
  - 100 SUB: rd<=rd-rs
  - 101 JMP: pc<=addr
  - 110 JZ: if R[rs]==0 then pc<=addr
  - 111 HALT
- FETCH: ram_read_e=1, ram_addr_read=pc. Next state DECODE.
- DECODE: IR<=ram_data_read; pc<=pc+1, wrapping modulo 2^ADDR_W (0xFF->0x00). Next state EXEC.
- EXEC, by opcode:
  - LOAD: ram_read_e=1, ram_addr_read=addr; next state MEM.
  - STORE: ram_write_e=1, ram_addr_write=addr, ram_data_write=R[rs] sampled in this cycle; next state FETCH.
  - ADD/SUB: rd updated; result wraps modulo 2^DATA_W; carry = bit DATA_W of the extended sum; borrow = rs>rd unsigned; zero = result==0. Next state FETCH.
  - JMP/JZ: pc overrides the DECODE increment. JZ not taken leaves pc at +1. Next state FETCH.
  - HALT: next state HALT.
  - NOP: next state FETCH.
- MEM: rd<=ram_data_read. Next state FETCH.
- HALT: absorbing state. halted=1, no RAM enables, exits only on rst.
- Latency: NOP/ADD/SUB/STORE/JMP/JZ take 3 cycles; LOAD takes 4.
- Outside the cases above: ram_read_e=0, ram_write_e=0; write address/data = 0 whenever ram_write_e=0.
- Edge cases:
  - Read and write enables are never high in the same cycle.
  - rd==rs for ADD doubles the register; for SUB it gives 0 with zero=1, carry=0.
  - Flags are unchanged by every opcode except ADD/SUB.
  - A LOAD result is visible to the very next instruction.

Decomposition:
- Package minicpu_pkg holds:
  - opcode localparams;
  - state encoding: FETCH, DECODE, EXEC, MEM, HALT;
  - field-offset functions of REG_AW/ADDR_W.
- Sub-module minicpu_regfile: NREG x DATA_W, two combinational read ports, one synchronous write port, asynchronous active-high reset to 0.
- FSM, PC, IR and ALU stay in minicpu_core.

Test Plan (defaults; RAM model with 1-cycle read latency):
- rst pulse mid-cycle during a STORE EXEC -> ram_write_e drops within the same delta; after release, the first FETCH reads address 0x00; pc=0 and all registers=0.
- M[0]=0x0809 (LOAD r1,0x10), M[0x10]=0x00FF -> read of 0x10 in cycle 3, r1=0x00FF after cycle 4; pc=1.
- Load r1=0xFFFF, r2=0x0001, then M[n]=0x004B (ADD r1,r2) -> r1=0x0000, zero_flag=1, carry_flag=1.
- r1=0x1234, M[n]=0x1022 (STORE r1,0x20) -> exactly one cycle with ram_write_e=1, addr 0x20, data 0x1234; read enable 0 in that cycle.
- r3=0, M[n]=0x02E6 (JZ r3,0x05) -> next fetch address 0x05. Repeat with r3=1 -> next fetch address n+1.
- pc=0xFF holding NOP -> next fetch address 0x00. M[n]=0x0007 (HALT) -> halted=1, no enables for 100 cycles, cleared by rst.

Source files
------------

// File: rtl/minicpu_pkg.sv
// Shared definitions for the minicpu core: opcodes, FSM states and
// instruction field offsets.
package minicpu_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_JMP   = 3'd5;
  localparam logic [2:0] OP_JZ    = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  // Instruction layout, LSB first: op[2:0], rd, rs, addr
  function automatic int rd_lsb();
    return 3;
  endfunction

  function automatic int rs_lsb(input int reg_aw);
    return 3 + reg_aw;
  endfunction

  function automatic int addr_lsb(input int reg_aw);
    return 3 + 2 * reg_aw;
  endfunction

  function automatic int instr_bits(input int reg_aw, input int addr_w);
    return 3 + 2 * reg_aw + addr_w;
  endfunction

endpackage

// File: rtl/minicpu_regfile.sv
// General register file: two combinational read ports, one synchronous
// write port, cleared by the asynchronous reset.
module minicpu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NREG];

  // Register storage: cleared on reset, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/minicpu_core.sv
// Multicycle FETCH/DECODE/EXEC/MEM processor core sharing one synchronous
// RAM for program and data. RAM strobes are decoded from the current state
// so a reset cuts any access immediately.
module minicpu_core
  import minicpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ram_data_read,
  output logic [ADDR_W-1:0] ram_addr_read,
  output logic              ram_read_e,
  output logic [DATA_W-1:0] ram_data_write,
  output logic [ADDR_W-1:0] ram_addr_write,
  output logic              ram_write_e,
  output logic [ADDR_W-1:0] pc,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted
);

  localparam int REG_AW   = $clog2(NREG);
  localparam int INSTR_W  = instr_bits(REG_AW, ADDR_W);
  localparam int RD_LSB   = rd_lsb();
  localparam int RS_LSB   = rs_lsb(REG_AW);
  localparam int ADDR_LSB = addr_lsb(REG_AW);

  generate
    if (DATA_W < INSTR_W) begin : g_width_check
      $error("minicpu_core: DATA_W too small for the instruction format");
    end
    if (NREG < 2 || (1 << REG_AW) != NREG) begin : g_nreg_check
      $error("minicpu_core: NREG must be a power of two and at least 2");
    end
  endgenerate

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_zero;
  logic                r_carry;

  logic [2:0]          w_op;
  logic [REG_AW-1:0]   w_rd;
  logic [REG_AW-1:0]   w_rs;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_rs_val;
  logic [DATA_W:0]     w_alu;
  logic                w_rf_we;
  logic [DATA_W-1:0]   w_rf_wdata;
  logic                w_is_alu;

  assign w_op   = r_ir[2:0];
  assign w_rd   = r_ir[RD_LSB +: REG_AW];
  assign w_rs   = r_ir[RS_LSB +: REG_AW];
  assign w_addr = r_ir[ADDR_LSB +: ADDR_W];

  assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB);

  minicpu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_rf_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (w_rd),
    .o_rdata_a (w_rd_val),
    .i_raddr_b (w_rs),
    .o_rdata_b (w_rs_val)
  );

  // ALU: one extra bit holds the ADD carry or the SUB borrow
  always_comb begin
    w_alu = '0;
    if (w_op == OP_SUB) begin
      w_alu = {1'b0, w_rd_val} - {1'b0, w_rs_val};
    end else begin
      w_alu = {1'b0, w_rd_val} + {1'b0, w_rs_val};
    end
  end

  // Register write-back: ALU result in EXEC, loaded word in MEM
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_wdata = '0;
    if (r_state == S_EXEC && w_is_alu) begin
      w_rf_we    = 1'b1;
      w_rf_wdata = w_alu[DATA_W-1:0];
    end else if (r_state == S_MEM) begin
      w_rf_we    = 1'b1;
      w_rf_wdata = ram_data_read;
    end
  end

  // RAM strobes decoded from state; write address/data stay 0 when idle
  always_comb begin
    ram_read_e     = 1'b0;
    ram_addr_read  = '0;
    ram_write_e    = 1'b0;
    ram_addr_write = '0;
    ram_data_write = '0;
    if (rst) begin
      ram_read_e = 1'b1;
    end else begin
      case (r_state)
        S_FETCH: begin
          ram_read_e    = 1'b1;
          ram_addr_read = r_pc;
        end
        S_EXEC: begin
          if (w_op == OP_LOAD) begin
            ram_read_e    = 1'b1;
            ram_addr_read = w_addr;
          end else if (w_op == OP_STORE) begin
            ram_write_e    = 1'b1;
            ram_addr_write = w_addr;
            ram_data_write = w_rs_val;
          end
        end
        default: ;
      endcase
    end
  end

  // Control FSM with PC, instruction register and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_ir    <= ram_data_read[INSTR_W-1:0];
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          case (w_op)
            OP_LOAD: r_state <= S_MEM;
            OP_ADD, OP_SUB: begin
              r_zero  <= (w_alu[DATA_W-1:0] == '0);
              r_carry <= w_alu[DATA_W];
            end
            OP_JMP: r_pc <= w_addr;
            OP_JZ: begin
              if (w_rs_val == '0) begin
                r_pc <= w_addr;
              end
            end
            OP_HALT: r_state <= S_HALT;
            default: ;
          endcase
        end
        S_MEM:   r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign pc         = r_pc;
  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;
  assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_minicpu_core.sv
// Self-checking bench for minicpu_core: an instruction-level reference model
// predicts the RAM bus activity of every cycle plus the final architectural
// state, for directed programs and random memory images.
module tb_minicpu_core;

  typedef struct packed {
    logic        re;
    logic [7:0]  ra;
    logic        we;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic [7:0]  pcv;
    logic        z;
    logic        c;
    logic        h;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tbLoad = 1'b0;
  logic [15:0] image [256];
  logic [15:0] mem [256];
  logic [15:0] ramRdata;

  logic [7:0]  ramAddrRead;
  logic        ramReadE;
  logic [15:0] ramDataWrite;
  logic [7:0]  ramAddrWrite;
  logic        ramWriteE;
  logic [7:0]  pcOut;
  logic        zeroFlag;
  logic        carryFlag;
  logic        haltedOut;

  int errorCount = 0;
  int checkCount = 0;

  minicpu_core #(
    .DATA_W (16),
    .ADDR_W (8),
    .NREG   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_data_read  (ramRdata),
    .ram_addr_read  (ramAddrRead),
    .ram_read_e     (ramReadE),
    .ram_data_write (ramDataWrite),
    .ram_addr_write (ramAddrWrite),
    .ram_write_e    (ramWriteE),
    .pc             (pcOut),
    .zero_flag      (zeroFlag),
    .carry_flag     (carryFlag),
    .halted         (haltedOut)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency; tbLoad copies a fresh image
  always @(posedge clk) begin
    if (tbLoad) begin
      for (int i = 0; i < 256; i++) mem[i] <= image[i];
    end else if (ramWriteE) begin
      mem[ramAddrWrite] <= ramDataWrite;
    end
    if (ramReadE) ramRdata <= mem[ramAddrRead];
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] addr);
    return {1'b0, addr, rs, rd, op};
  endfunction

  function automatic bus_t mk(input logic re, input logic [7:0] ra, input logic we,
                              input logic [7:0] wa, input logic [15:0] wd,
                              input logic [7:0] p, input logic z, input logic c,
                              input logic h);
    bus_t b;
    b.re = re; b.ra = ra; b.we = we; b.wa = wa; b.wd = wd;
    b.pcv = p; b.z = z; b.c = c; b.h = h;
    return b;
  endfunction

  task automatic clear_image();
    for (int i = 0; i < 256; i++) image[i] = 16'h0000;
  endtask

  // Runs image from reset, comparing every cycle against the ISA model
  task automatic run_program(input string name, input int ncycles);
    bus_t        expQ[$];
    bus_t        obs;
    logic [15:0] m [256];
    logic [15:0] r [4];
    logic [7:0]  p;
    logic        z, c, h;
    logic [15:0] ir;
    logic [2:0]  op;
    logic [1:0]  rd, rs;
    logic [7:0]  a;
    int          s;
    int          memDiff;
    int          firstDiff;

    for (int i = 0; i < 256; i++) m[i] = image[i];
    for (int i = 0; i < 4; i++) r[i] = 16'h0000;
    p = 8'h00; z = 1'b0; c = 1'b0; h = 1'b0;
    while (expQ.size() < ncycles) begin
      if (h) begin
        expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b1));
      end else begin
        expQ.push_back(mk(1'b1, p, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
        ir = m[p];
        expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
        p = p + 8'd1;
        op = ir[2:0]; rd = ir[4:3]; rs = ir[6:5]; a = ir[14:7];
        case (op)
          3'd1: begin
            expQ.push_back(mk(1'b1, a, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
            expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
            r[rd] = m[a];
          end
          3'd2: begin
            expQ.push_back(mk(1'b0, 8'h00, 1'b1, a, r[rs], p, z, c, 1'b0));
            m[a] = r[rs];
          end
          3'd3: begin
            expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
            s = int'(r[rd]) + int'(r[rs]);
            c = (s > 65535);
            r[rd] = s[15:0];
            z = (r[rd] == 16'h0000);
          end
          3'd4: begin
            expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
            c = (r[rs] > r[rd]);
            s = int'(r[rd]) - int'(r[rs]);
            r[rd] = s[15:0];
            z = (r[rd] == 16'h0000);
          end
          3'd5: begin
            expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
            p = a;
          end
          3'd6: begin
            expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
            if (r[rs] == 16'h0000) p = a;
          end
          3'd7: begin
            expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
            h = 1'b1;
          end
          default: begin
            expQ.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, p, z, c, 1'b0));
          end
        endcase
      end
    end

    rst = 1'b1;
    tbLoad = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tbLoad = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < expQ.size(); i++) begin
      obs = {ramReadE, (ramReadE ? ramAddrRead : 8'h00), ramWriteE, ramAddrWrite,
             ramDataWrite, pcOut, zeroFlag, carryFlag, haltedOut};
      checkCount++;
      if (obs !== expQ[i]) begin
        errorCount++;
        $display("[TB] FAIL %s bus cycle %0d: got %h expected %h", name, i, obs, expQ[i]);
      end
      @(negedge clk);
      #1;
    end

    checkCount++;
    if ({pcOut, zeroFlag, carryFlag, haltedOut} !== {p, z, c, h}) begin
      errorCount++;
      $display("[TB] FAIL %s final pc/z/c/halted: got %h/%b/%b/%b expected %h/%b/%b/%b",
               name, pcOut, zeroFlag, carryFlag, haltedOut, p, z, c, h);
    end
    memDiff = 0;
    firstDiff = -1;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== m[i]) begin
        memDiff++;
        if (firstDiff < 0) firstDiff = i;
      end
    end
    checkCount++;
    if (memDiff != 0) begin
      errorCount++;
      $display("[TB] FAIL %s final memory: %0d words differ, first at %0d got %h expected %h",
               name, memDiff, firstDiff, mem[firstDiff], m[firstDiff]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkCount++;
    if (ramReadE !== 1'b1) begin errorCount++; $display("[TB] FAIL reset read_e: got %b expected 1", ramReadE); end
    checkCount++;
    if (ramAddrRead !== 8'h00) begin errorCount++; $display("[TB] FAIL reset addr_read: got %h expected 00", ramAddrRead); end
    checkCount++;
    if (ramWriteE !== 1'b0) begin errorCount++; $display("[TB] FAIL reset write_e: got %b expected 0", ramWriteE); end
    checkCount++;
    if (ramAddrWrite !== 8'h00) begin errorCount++; $display("[TB] FAIL reset addr_write: got %h expected 00", ramAddrWrite); end
    checkCount++;
    if (ramDataWrite !== 16'h0000) begin errorCount++; $display("[TB] FAIL reset data_write: got %h expected 0000", ramDataWrite); end
    checkCount++;
    if (haltedOut !== 1'b0) begin errorCount++; $display("[TB] FAIL reset halted: got %b expected 0", haltedOut); end
    checkCount++;
    if (pcOut !== 8'h00) begin errorCount++; $display("[TB] FAIL reset pc: got %h expected 00", pcOut); end
    checkCount++;
    if ({zeroFlag, carryFlag} !== 2'b00) begin errorCount++; $display("[TB] FAIL reset flags: got %b%b expected 00", zeroFlag, carryFlag); end
  endtask

  task automatic test_load();
    clear_image();
    image[8'h00] = 16'h0809;
    image[8'h01] = enc(3'd2, 2'd0, 2'd1, 8'h30);
    image[8'h02] = 16'h0007;
    image[8'h10] = 16'h00FF;
    run_program("load", 16);
    checkCount++;
    if (mem[8'h30] !== 16'h00FF) begin errorCount++; $display("[TB] FAIL load r1 stored: got %h expected 00ff", mem[8'h30]); end
  endtask

  task automatic test_add_carry();
    clear_image();
    image[8'h00] = 16'h0809;
    image[8'h01] = enc(3'd1, 2'd2, 2'd0, 8'h11);
    image[8'h02] = 16'h004B;
    image[8'h03] = enc(3'd2, 2'd0, 2'd1, 8'h30);
    image[8'h04] = 16'h0007;
    image[8'h10] = 16'hFFFF;
    image[8'h11] = 16'h0001;
    image[8'h30] = 16'h5555;
    run_program("add_carry", 24);
    checkCount++;
    if ({zeroFlag, carryFlag} !== 2'b11) begin errorCount++; $display("[TB] FAIL add flags: got z=%b c=%b expected z=1 c=1", zeroFlag, carryFlag); end
    checkCount++;
    if (mem[8'h30] !== 16'h0000) begin errorCount++; $display("[TB] FAIL add result: got %h expected 0000", mem[8'h30]); end
  endtask

  task automatic test_sub_self();
    clear_image();
    image[8'h00] = enc(3'd1, 2'd2, 2'd0, 8'h11);
    image[8'h01] = enc(3'd4, 2'd2, 2'd2, 8'h00);
    image[8'h02] = 16'h0007;
    image[8'h11] = 16'h0005;
    run_program("sub_self", 14);
    checkCount++;
    if ({zeroFlag, carryFlag} !== 2'b10) begin errorCount++; $display("[TB] FAIL sub self flags: got z=%b c=%b expected z=1 c=0", zeroFlag, carryFlag); end
  endtask

  task automatic test_store();
    clear_image();
    image[8'h00] = 16'h0809;
    image[8'h01] = 16'h1022;
    image[8'h02] = 16'h0007;
    image[8'h10] = 16'h1234;
    run_program("store", 14);
    checkCount++;
    if (mem[8'h20] !== 16'h1234) begin errorCount++; $display("[TB] FAIL store word: got %h expected 1234", mem[8'h20]); end
  endtask

  task automatic test_jz(input logic [15:0] r3Value, input logic [7:0] expPc);
    clear_image();
    image[8'h00] = enc(3'd1, 2'd3, 2'd0, 8'h10);
    image[8'h01] = 16'h02E6;
    image[8'h02] = 16'h0007;
    image[8'h05] = 16'h0007;
    image[8'h10] = r3Value;
    run_program("jz", 12);
    checkCount++;
    if (pcOut !== expPc) begin errorCount++; $display("[TB] FAIL jz r3=%h halt pc: got %h expected %h", r3Value, pcOut, expPc); end
  endtask

  task automatic test_pc_wrap();
    clear_image();
    image[8'h00] = enc(3'd5, 2'd0, 2'd0, 8'h80);
    image[8'h01] = 16'h0007;
    image[8'h80] = enc(3'd2, 2'd0, 2'd0, 8'h00);
    image[8'h81] = enc(3'd5, 2'd0, 2'd0, 8'hFF);
    image[8'hFF] = 16'h0000;
    run_program("pc_wrap", 22);
    checkCount++;
    if (pcOut !== 8'h02) begin errorCount++; $display("[TB] FAIL pc wrap halt pc: got %h expected 02", pcOut); end
  endtask

  task automatic test_halt();
    clear_image();
    image[8'h00] = 16'h0000;
    image[8'h01] = 16'h0007;
    run_program("halt", 106);
    checkCount++;
    if (haltedOut !== 1'b1) begin errorCount++; $display("[TB] FAIL halt state: got %b expected 1", haltedOut); end
    rst = 1'b1;
    #1;
    checkCount++;
    if (haltedOut !== 1'b0) begin errorCount++; $display("[TB] FAIL halt cleared by rst: got %b expected 0", haltedOut); end
  endtask

  task automatic test_reset_mid_store();
    clear_image();
    image[8'h00] = 16'h0809;
    image[8'h01] = 16'h1022;
    image[8'h02] = 16'h0007;
    image[8'h10] = 16'h1234;
    rst = 1'b1;
    tbLoad = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tbLoad = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
    end
    checkCount++;
    if ({ramWriteE, ramAddrWrite, ramDataWrite} !== {1'b1, 8'h20, 16'h1234}) begin
      errorCount++;
      $display("[TB] FAIL mid store pulse: got %b %h %h expected 1 20 1234", ramWriteE, ramAddrWrite, ramDataWrite);
    end
    #1;
    rst = 1'b1;
    #1;
    checkCount++;
    if ({ramWriteE, ramAddrWrite, ramDataWrite, ramReadE, ramAddrRead, pcOut, haltedOut}
        !== {1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0}) begin
      errorCount++;
      $display("[TB] FAIL mid store reset outputs: got we=%b wa=%h wd=%h re=%b ra=%h pc=%h h=%b",
               ramWriteE, ramAddrWrite, ramDataWrite, ramReadE, ramAddrRead, pcOut, haltedOut);
    end
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (mem[8'h20] !== 16'h0000) begin errorCount++; $display("[TB] FAIL mid store cut: got %h expected 0000", mem[8'h20]); end

    clear_image();
    image[8'h00] = enc(3'd2, 2'd0, 2'd0, 8'h40);
    image[8'h01] = enc(3'd2, 2'd0, 2'd1, 8'h41);
    image[8'h02] = enc(3'd2, 2'd0, 2'd2, 8'h42);
    image[8'h03] = enc(3'd2, 2'd0, 2'd3, 8'h43);
    image[8'h04] = 16'h0007;
    for (int i = 8'h40; i < 8'h44; i++) image[i] = 16'hAAAA;
    run_program("regs_after_reset", 16);
    for (int i = 8'h40; i < 8'h44; i++) begin
      checkCount++;
      if (mem[i] !== 16'h0000) begin errorCount++; $display("[TB] FAIL reg %0d after reset: got %h expected 0000", i - 8'h40, mem[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[2:0] == 3'd7 && $urandom_range(0, 3) != 0) w[2:0] = 3'd3;
        image[i] = w;
      end
      run_program("random", 300);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add_carry();
    test_sub_self();
    test_store();
    test_jz(16'h0000, 8'h06);
    test_jz(16'h0001, 8'h03);
    test_pc_wrap();
    test_halt();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
